// File: rtl/resp_chk_pkg.sv
`default_nettype none
// ============================================================================
// resp_chk_pkg : shared types, the CRC-32 polynomial and the result-bus fold
// Rev 1.0
// ============================================================================
package resp_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] c_CRC32_POLY = 32'h04C11DB7;
  localparam int          c_CHUNK_W    = 32;
  // Widest result bus the fold accepts; narrower buses are zero-extended,
  // so the surplus chunks contribute nothing to the XOR.
  localparam int          c_FOLD_MAX_W = 1024;

  function automatic logic [c_CHUNK_W-1:0] fold(input logic [c_FOLD_MAX_W-1:0] d);
    logic [c_CHUNK_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < c_FOLD_MAX_W / c_CHUNK_W; i++) begin
      acc = acc ^ d[i*c_CHUNK_W +: c_CHUNK_W];
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/resp_misr.sv
`default_nettype none
// ============================================================================
// resp_misr : registered fold of the result bus feeding a MISR signature
// Rev 1.0
// ============================================================================
module resp_misr
  import resp_chk_pkg::*;
#(
  parameter int              DATA_W = 754,
  parameter int              SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY  = c_CRC32_POLY,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load_seed,
  input  logic [DATA_W-1:0] din,
  output logic              fold_vld,
  output logic [SIG_W-1:0]  sig
);

  logic [c_FOLD_MAX_W-1:0] w_pad;
  logic [SIG_W-1:0]        r_fold_q;
  logic [SIG_W-1:0]        r_sig;
  logic                    r_fold_vld;

  generate
    if (DATA_W < c_FOLD_MAX_W) begin : g_pad
      assign w_pad = {{(c_FOLD_MAX_W-DATA_W){1'b0}}, din};
    end else begin : g_full
      assign w_pad = din[c_FOLD_MAX_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fold_q   <= '0;
      r_fold_vld <= 1'b0;
      r_sig      <= SEED;
    end else if (load_seed) begin
      r_fold_vld <= 1'b0;
      r_sig      <= SEED;
    end else begin
      r_fold_vld <= en;
      if (en) begin
        r_fold_q <= fold(w_pad);
      end
      if (r_fold_vld) begin
        r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ r_fold_q;
      end
    end
  end

  assign fold_vld = r_fold_vld;
  assign sig      = r_sig;

endmodule
`default_nettype wire

// File: rtl/response_signature_checker.sv
`default_nettype none
// ============================================================================
// response_signature_checker : absorbs NUM_VEC result samples into a MISR and
// compares the final signature against a golden value
// Rev 1.0
// ============================================================================
module response_signature_checker
  import resp_chk_pkg::*;
#(
  parameter int               DATA_W  = 754,
  parameter int               SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = c_CRC32_POLY,
  parameter logic [SIG_W-1:0] SEED    = '0,
  parameter int               NUM_VEC = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           y_valid,
  input  logic [DATA_W-1:0]              y,
  input  logic [SIG_W-1:0]               golden_sig,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           overrun,
  output logic [SIG_W-1:0]               signature,
  output logic [$clog2(NUM_VEC+1)-1:0]   vec_count
);

  localparam int               VC_W      = $clog2(NUM_VEC + 1);
  localparam logic [VC_W-1:0]  c_NUM_VEC = VC_W'(NUM_VEC);

  state_t          r_state;
  logic [VC_W-1:0] r_acc_cnt;
  logic [VC_W-1:0] r_vec_count;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            r_overrun;

  logic            w_load;
  logic            w_accept;
  logic            w_fold_vld;
  logic [SIG_W-1:0] w_sig;

  assign w_load   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_accept = (r_state == RUN) && y_valid && (r_acc_cnt < c_NUM_VEC);

  resp_misr #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_accept),
    .load_seed (w_load),
    .din       (y),
    .fold_vld  (w_fold_vld),
    .sig       (w_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc_cnt   <= '0;
      r_vec_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_fold_vld) begin
        r_vec_count <= r_vec_count + VC_W'(1);
      end
      if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + VC_W'(1);
      end
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= RUN;
            r_acc_cnt   <= '0;
            r_vec_count <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_overrun   <= 1'b0;
          end
        end
        RUN: begin
          if (y_valid && (r_acc_cnt >= c_NUM_VEC)) begin
            r_overrun <= 1'b1;
          end
          // Wait for the last fold to land in the signature before comparing.
          if (r_vec_count == c_NUM_VEC) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (y_valid) begin
            r_overrun <= 1'b1;
          end
          r_pass  <= (w_sig == golden_sig);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign overrun   = r_overrun;
  assign signature = w_sig;
  assign vec_count = r_vec_count;

endmodule
`default_nettype wire

// File: tb/tb_response_signature_checker.sv
`default_nettype none
// ============================================================================
// tb_response_signature_checker : directed checks on three parameterisations
// Rev 1.0
// ============================================================================
module tb_response_signature_checker;

  localparam int DATA_W = 754;
  localparam int SIG_W  = 32;

  localparam logic [DATA_W-1:0] c_ZERO = '0;
  localparam logic [DATA_W-1:0] c_ONE  = DATA_W'(1);
  localparam logic [DATA_W-1:0] c_B32  = c_ONE << 32;
  localparam logic [DATA_W-1:0] c_B753 = c_ONE << 753;
  localparam logic [DATA_W-1:0] c_ALL1 = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              y_valid;
  logic [DATA_W-1:0] y;
  logic              start_a, start_b, start_c;
  logic [SIG_W-1:0]  golden_a, golden_b, golden_c;

  logic             busy_a, done_a, pass_a, overrun_a;
  logic [SIG_W-1:0] sig_a;
  logic [4:0]       vec_a;
  logic             busy_b, done_b, pass_b, overrun_b;
  logic [SIG_W-1:0] sig_b;
  logic [0:0]       vec_b;
  logic             busy_c, done_c, pass_c, overrun_c;
  logic [SIG_W-1:0] sig_c;
  logic [0:0]       vec_c;

  int n_cmp = 0;
  int n_err = 0;

  response_signature_checker u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y_valid(y_valid), .y(y),
    .golden_sig(golden_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .overrun(overrun_a), .signature(sig_a), .vec_count(vec_a)
  );

  response_signature_checker #(.NUM_VEC(1), .SEED(32'h0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y_valid(y_valid), .y(y),
    .golden_sig(golden_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .overrun(overrun_b), .signature(sig_b), .vec_count(vec_b)
  );

  response_signature_checker #(.NUM_VEC(1), .SEED(32'h80000000)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .y_valid(y_valid), .y(y),
    .golden_sig(golden_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .overrun(overrun_c), .signature(sig_c), .vec_count(vec_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    start_a = (which == 0);
    start_b = (which == 1);
    start_c = (which == 2);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Back-to-back samples: first, then rest..., with the final one set to last.
  task automatic send(input int n, input logic [DATA_W-1:0] first,
                      input logic [DATA_W-1:0] rest, input logic [DATA_W-1:0] last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      y_valid = 1'b1;
      y       = (i == 0) ? first : ((i == n - 1) ? last : rest);
    end
    @(negedge clk);
    y_valid = 1'b0;
    y       = c_ZERO;
  endtask

  function automatic logic sel_done(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic wait_done(input int which, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = sel_done(which);
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    y_valid  = 1'b0;
    y        = c_ZERO;
    start_a  = 1'b0;
    start_b  = 1'b0;
    start_c  = 1'b0;
    golden_a = '0;
    golden_b = '0;
    golden_c = '0;

    repeat (3) @(negedge clk);
    check("rst_sig_a",     64'(sig_a),     64'h0);
    check("rst_busy_a",    64'(busy_a),    64'h0);
    check("rst_done_a",    64'(done_a),    64'h0);
    check("rst_pass_a",    64'(pass_a),    64'h0);
    check("rst_overrun_a", 64'(overrun_a), 64'h0);
    check("rst_vec_a",     64'(vec_a),     64'h0);
    check("rst_sig_c",     64'(sig_c),     64'h80000000);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero run with exact latency of done
    golden_a = 32'h0;
    pulse_start(0);
    check("t1_busy_after_start", 64'(busy_a), 64'h1);
    check("t1_done_after_start", 64'(done_a), 64'h0);
    send(20, c_ZERO, c_ZERO, c_ZERO);
    check("t1_vec_k",   64'(vec_a),  64'd19);
    check("t1_done_k",  64'(done_a), 64'h0);
    @(negedge clk);
    check("t1_vec_k1",  64'(vec_a),  64'd20);
    check("t1_done_k1", 64'(done_a), 64'h0);
    @(negedge clk);
    check("t1_done_k2", 64'(done_a), 64'h0);
    check("t1_busy_k2", 64'(busy_a), 64'h1);
    @(negedge clk);
    check("t1_done_k3", 64'(done_a), 64'h1);
    check("t1_busy_k3", 64'(busy_a), 64'h0);
    check("t1_pass",    64'(pass_a), 64'h1);
    check("t1_sig",     64'(sig_a),  64'h0);
    check("t1_overrun", 64'(overrun_a), 64'h0);

    // Golden mismatch
    golden_a = 32'h1;
    pulse_start(0);
    check("t2_done_cleared", 64'(done_a), 64'h0);
    send(20, c_ZERO, c_ZERO, c_ZERO);
    wait_done(0, "t2_timeout");
    check("t2_pass", 64'(pass_a), 64'h0);
    check("t2_done", 64'(done_a), 64'h1);

    // One set bit in the first sample, shifted 19 times
    golden_a = 32'h00080000;
    pulse_start(0);
    send(20, c_ONE, c_ZERO, c_ZERO);
    wait_done(0, "t3_timeout");
    check("t3_sig",  64'(sig_a),  64'h00080000);
    check("t3_pass", 64'(pass_a), 64'h1);
    check("t3_vec",  64'(vec_a),  64'd20);

    // y_valid while DONE is ignored
    send(1, c_ONE, c_ONE, c_ONE);
    repeat (3) @(negedge clk);
    check("t3_done_ign_overrun", 64'(overrun_a), 64'h0);
    check("t3_done_ign_sig",     64'(sig_a),     64'h00080000);
    check("t3_done_ign_vec",     64'(vec_a),     64'd20);

    // 21 consecutive samples: the all-ones 21st is discarded
    pulse_start(0);
    send(21, c_ONE, c_ZERO, c_ALL1);
    wait_done(0, "t4_timeout");
    check("t4_overrun", 64'(overrun_a), 64'h1);
    check("t4_sig",     64'(sig_a),     64'h00080000);
    check("t4_vec",     64'(vec_a),     64'd20);
    check("t4_pass",    64'(pass_a),    64'h1);

    // Reset after the 10th sample, then a clean rerun
    pulse_start(0);
    send(10, c_ONE, c_ZERO, c_ZERO);
    check("t5_vec_pre", 64'(vec_a), 64'd9);
    check("t5_sig_pre", 64'(sig_a), 64'h100);
    rst_n = 1'b0;
    #1;
    check("t5_rst_sig",  64'(sig_a),  64'h0);
    check("t5_rst_busy", 64'(busy_a), 64'h0);
    check("t5_rst_done", 64'(done_a), 64'h0);
    check("t5_rst_pass", 64'(pass_a), 64'h0);
    check("t5_rst_vec",  64'(vec_a),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(0);
    send(20, c_ONE, c_ZERO, c_ZERO);
    wait_done(0, "t5_timeout");
    check("t5_sig",     64'(sig_a),     64'h00080000);
    check("t5_pass",    64'(pass_a),    64'h1);
    check("t5_overrun", 64'(overrun_a), 64'h0);

    // Single-sample instance: chunk fold
    golden_b = 32'h1;
    pulse_start(1);
    send(1, c_ONE, c_ZERO, c_ZERO);
    wait_done(1, "b1_timeout");
    check("b1_sig",  64'(sig_b),  64'h1);
    check("b1_pass", 64'(pass_b), 64'h1);
    check("b1_vec",  64'(vec_b),  64'h1);
    pulse_start(1);
    send(1, c_B32, c_ZERO, c_ZERO);
    wait_done(1, "b2_timeout");
    check("b2_sig_bit32", 64'(sig_b), 64'h1);
    pulse_start(1);
    send(1, c_B753, c_ZERO, c_ZERO);
    wait_done(1, "b3_timeout");
    check("b3_sig_bit753", 64'(sig_b), 64'h00020000);
    pulse_start(1);
    send(1, c_ONE | c_B32, c_ZERO, c_ZERO);
    wait_done(1, "b4_timeout");
    check("b4_sig_cancel", 64'(sig_b),  64'h0);
    check("b4_pass",       64'(pass_b), 64'h0);

    // Seed with MSB set exercises the feedback path
    golden_c = 32'h04C11DB7;
    pulse_start(2);
    send(1, c_ZERO, c_ZERO, c_ZERO);
    wait_done(2, "c1_timeout");
    check("c1_sig",  64'(sig_c),  64'h04C11DB7);
    check("c1_pass", 64'(pass_c), 64'h1);
    pulse_start(2);
    send(1, c_ONE, c_ZERO, c_ZERO);
    wait_done(2, "c2_timeout");
    check("c2_sig",  64'(sig_c),  64'h04C11DB6);
    check("c2_pass", 64'(pass_c), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
